// File: rtl/w_writeback_grf.sv
// Writeback stage and 32x32 general register file for the five-stage MIPS core.
// Decodes the W-stage instruction into a write triple, commits it to the register
// file, serves two combinational read ports with write-through bypass, and tracks
// retired instructions.
module w_writeback_grf #(
  parameter logic [31:0] RST_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_Instr,
  input  logic [31:0] W_pc,
  input  logic [31:0] W_ALUout,
  input  logic [31:0] W_DMout,
  input  logic [31:0] W_MDout,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        W_we,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic [31:0] retired,
  output logic [31:0] last_pc
);

  typedef enum logic [1:0] {SrcAlu, SrcDm, SrcMd, SrcPc8} src_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        wr_dec;
  logic [4:0]  dest;
  src_e        src;
  logic [31:0] pc_plus8;

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] retired_q, retired_d;
  logic [31:0] last_pc_q, last_pc_d;

  logic [31:0] rs_stored, rt_stored;

  // rs and shamt fields are never needed at writeback
  logic unused_instr_bits;
  assign unused_instr_bits = ^{W_Instr[25:21], W_Instr[10:6]};

  assign opcode   = W_Instr[31:26];
  assign funct    = W_Instr[5:0];
  assign pc_plus8 = W_pc + 32'd8;

  // Decode write enable, destination and result source from the W instruction
  always_comb begin
    wr_dec = 1'b0;
    dest   = 5'd0;
    src    = SrcAlu;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00: begin
            wr_dec = 1'b1;
            dest   = W_Instr[15:11];
            src    = SrcAlu;
          end
          6'h10, 6'h12: begin
            wr_dec = 1'b1;
            dest   = W_Instr[15:11];
            src    = SrcMd;
          end
          6'h09: begin
            wr_dec = 1'b1;
            dest   = W_Instr[15:11];
            src    = SrcPc8;
          end
          default: ;
        endcase
      end
      6'h0D, 6'h0C, 6'h08, 6'h0F: begin
        wr_dec = 1'b1;
        dest   = W_Instr[20:16];
        src    = SrcAlu;
      end
      6'h23, 6'h21, 6'h20: begin
        wr_dec = 1'b1;
        dest   = W_Instr[20:16];
        src    = SrcDm;
      end
      6'h03: begin
        wr_dec = 1'b1;
        dest   = 5'd31;
        src    = SrcPc8;
      end
      default: ;
    endcase
  end

  // Select write data; writes to $0 are suppressed but data still reflects the source
  always_comb begin
    W_WD = 32'd0;
    if (wr_dec) begin
      unique case (src)
        SrcAlu:  W_WD = W_ALUout;
        SrcDm:   W_WD = W_DMout;
        SrcMd:   W_WD = W_MDout;
        SrcPc8:  W_WD = pc_plus8;
        default: W_WD = 32'd0;
      endcase
    end
    W_we = wr_dec && (dest != 5'd0);
    W_A3 = W_we ? dest : 5'd0;
  end

  // Next-state for register file and retire tracking
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (W_we && (W_A3 == 5'(i))) regs_d[i] = W_WD;
    end
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    if (W_Instr != 32'd0) begin
      retired_d = retired_q + 32'd1;
      last_pc_d = W_pc;
    end
  end

  // State registers; synchronous reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
      retired_q <= 32'd0;
      last_pc_q <= RST_PC;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Storage lookup for both read ports ($0 has no storage)
  always_comb begin
    rs_stored = 32'd0;
    rt_stored = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (rs_addr == 5'(i)) rs_stored = regs_q[i];
      if (rt_addr == 5'(i)) rt_stored = regs_q[i];
    end
  end

  // Read ports with same-cycle write-through bypass
  always_comb begin
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (W_we && (rs_addr == W_A3)) begin
      rs_data = W_WD;
    end else begin
      rs_data = rs_stored;
    end
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (W_we && (rt_addr == W_A3)) begin
      rt_data = W_WD;
    end else begin
      rt_data = rt_stored;
    end
  end

  assign retired = retired_q;
  assign last_pc = last_pc_q;

endmodule

// File: tb/tb_w_writeback_grf.sv
// Directed testbench for w_writeback_grf with hand-computed expected values.
module tb_w_writeback_grf;

  logic        clk;
  logic        reset;
  logic [31:0] W_Instr, W_pc, W_ALUout, W_DMout, W_MDout;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        W_we;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic [31:0] retired, last_pc;

  int checks = 0;
  int errors = 0;

  w_writeback_grf #(.RST_PC(32'h0000_3000)) dut (
    .clk      (clk),
    .reset    (reset),
    .W_Instr  (W_Instr),
    .W_pc     (W_pc),
    .W_ALUout (W_ALUout),
    .W_DMout  (W_DMout),
    .W_MDout  (W_MDout),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .W_we     (W_we),
    .W_A3     (W_A3),
    .W_WD     (W_WD),
    .retired  (retired),
    .last_pc  (last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] md);
    W_Instr  = instr;
    W_pc     = pc;
    W_ALUout = alu;
    W_DMout  = dm;
    W_MDout  = md;
    #1;
  endtask

  task automatic idle();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b);
    rs_addr = a;
    rt_addr = b;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    idle();
    step();
    step();
    reset = 1'b0;

    // Reset state
    read2(5'd5, 5'd31);
    check_eq("rst_we", 32'(W_we), 32'd0);
    check_eq("rst_a3", 32'(W_A3), 32'd0);
    check_eq("rst_wd", W_WD, 32'd0);
    check_eq("rst_rs", rs_data, 32'd0);
    check_eq("rst_rt", rt_data, 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_last_pc", last_pc, 32'h0000_3000);

    // ori $8 with bypass, then from storage
    apply(32'h3408_1234, 32'h3004, 32'h1234, 32'h0, 32'h0);
    read2(5'd8, 5'd0);
    check_eq("ori_we", 32'(W_we), 32'd1);
    check_eq("ori_a3", 32'(W_A3), 32'd8);
    check_eq("ori_bypass", rs_data, 32'h1234);
    step();
    idle();
    check_eq("ori_stored", rs_data, 32'h1234);
    check_eq("ori_retired", retired, 32'd1);
    check_eq("ori_last_pc", last_pc, 32'h3004);

    // jal writes $31 = pc+8
    apply(32'h0C00_0C10, 32'h3010, 32'h0, 32'h0, 32'h0);
    check_eq("jal_a3", 32'(W_A3), 32'd31);
    check_eq("jal_wd", W_WD, 32'h3018);
    step();
    idle();
    read2(5'd31, 5'd8);
    check_eq("jal_r31", rs_data, 32'h3018);
    check_eq("jal_r8_kept", rt_data, 32'h1234);

    // lw $9 takes DMout, not ALUout
    apply(32'h8C09_0000, 32'h3014, 32'h0000_0100, 32'hFFFF_FF80, 32'h0);
    check_eq("lw_wd", W_WD, 32'hFFFF_FF80);
    step();
    idle();
    read2(5'd9, 5'd0);
    check_eq("lw_r9", rs_data, 32'hFFFF_FF80);

    // mflo $10 takes MDout
    apply(32'h0000_5012, 32'h3018, 32'h0000_0100, 32'h0, 32'h7);
    step();
    idle();
    read2(5'd10, 5'd0);
    check_eq("mflo_r10", rs_data, 32'h7);

    // addu targeting $0 is suppressed
    apply(32'h0022_0021, 32'h301C, 32'hDEAD_BEEF, 32'h0, 32'h0);
    read2(5'd0, 5'd0);
    check_eq("r0_we", 32'(W_we), 32'd0);
    check_eq("r0_a3", 32'(W_A3), 32'd0);
    check_eq("r0_rs", rs_data, 32'd0);
    step();

    // sw: no write, but retires
    apply(32'hAC08_0000, 32'h3020, 32'h55, 32'h0, 32'h0);
    check_eq("sw_we", 32'(W_we), 32'd0);
    check_eq("sw_wd", W_WD, 32'd0);
    step();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sw_r8", rs_data, 32'h1234);
    check_eq("sw_r9", rt_data, 32'hFFFF_FF80);
    check_eq("sw_retired", retired, 32'd6);
    check_eq("sw_last_pc", last_pc, 32'h3020);

    // Both ports on $8 during a write to $8
    apply(32'h0000_4021, 32'h3024, 32'hA5A5_A5A5, 32'h0, 32'h0);
    read2(5'd8, 5'd8);
    check_eq("dual_rs", rs_data, 32'hA5A5_A5A5);
    check_eq("dual_rt", rt_data, 32'hA5A5_A5A5);
    step();
    // Back-to-back: $9 written right after $8
    apply(32'h0000_4821, 32'h3028, 32'h1111_2222, 32'h0, 32'h0);
    read2(5'd8, 5'd9);
    check_eq("b2b_r8_stored", rs_data, 32'hA5A5_A5A5);
    check_eq("b2b_r9_bypass", rt_data, 32'h1111_2222);
    step();
    idle();
    check_eq("b2b_r8_after", rs_data, 32'hA5A5_A5A5);
    check_eq("b2b_r9_after", rt_data, 32'h1111_2222);

    // jalr $5 with pc+8 wrapping past 2^32
    apply(32'h03E0_2809, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    check_eq("jalr_a3", 32'(W_A3), 32'd5);
    check_eq("jalr_wd", W_WD, 32'h0000_0004);
    step();
    idle();
    read2(5'd5, 5'd0);
    check_eq("jalr_r5", rs_data, 32'h0000_0004);
    check_eq("jalr_retired", retired, 32'd9);

    // Reset during a write drops the write
    apply(32'h3408_1234, 32'h302C, 32'h0000_9999, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    read2(5'd8, 5'd9);
    check_eq("rstw_r8", rs_data, 32'd0);
    check_eq("rstw_r9", rt_data, 32'd0);
    check_eq("rstw_retired", retired, 32'd0);
    check_eq("rstw_last_pc", last_pc, 32'h0000_3000);

    // Retire counter wraps from all-ones to zero
    apply(32'hAC08_0000, 32'h3030, 32'h0, 32'h0, 32'h0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    step();
    idle();
    check_eq("wrap_retired", retired, 32'd0);
    check_eq("wrap_last_pc", last_pc, 32'h3030);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
